// File: rtl/wb_timer_if.sv
// wb_timer_if: Wishbone classic bus bundle between the interconnect and wb_timer.
interface wb_timer_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic [2:0]  wb_cti_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_timer.sv
// wb_timer: Wishbone-slave down-counter timer with level interrupt.
// Define WB_TIMER_PRESCALER_EN to build the PRESC register and prescaler counter.
module wb_timer #(
  parameter int PRESC_W = 16
) (
  input  logic      sys_clk,
  input  logic      sys_rst,
  wb_timer_if.slave wb,
  output logic      irq_o
);
  logic [2:0]  ctrl_q, ctrl_d, idx;
  logic        exp_q, exp_d, ack_q, tick, acc, wr, expiry, unused;
  logic [31:0] reload_q, reload_d, count_q, count_d, dat_q, rd, presc_rd;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = s[i] ? n[8*i+:8] : o[8*i+:8];
    return r;
  endfunction
  assign idx    = wb.wb_adr_i[4:2];
  assign acc    = wb.wb_cyc_i && wb.wb_stb_i && !ack_q;
  assign wr     = acc && wb.wb_we_i;
  assign expiry = tick && count_q == 32'd0;
  assign unused = ^{wb.wb_cti_i, wb.wb_adr_i[31:5], wb.wb_adr_i[1:0]};
  assign rd = idx == 3'd0 ? {29'd0, ctrl_q} :
              idx == 3'd1 ? {31'd0, exp_q} :
              idx == 3'd2 ? reload_q :
              idx == 3'd3 ? count_q :
              idx == 3'd4 ? presc_rd : 32'd0;
`ifdef WB_TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  assign tick     = ctrl_q[0] && pcnt_q == presc_q;
  assign presc_rd = 32'(presc_q);
  assign presc_d  = (wr && idx == 3'd4) ? PRESC_W'(merge(32'(presc_q), wb.wb_dat_i, wb.wb_sel_i)) : presc_q;
  // a shrunk PRESC below pcnt lets pcnt run on and wrap rather than resetting it
  assign pcnt_d   = (!ctrl_q[0] || tick) ? '0 : pcnt_q + PRESC_W'(1);
  always_ff @(posedge sys_clk or negedge sys_rst)
    if (!sys_rst) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
`else
  localparam int unused_presc_w = PRESC_W;
  assign tick     = ctrl_q[0];
  assign presc_rd = 32'd0;
`endif
  always_comb begin
    ctrl_d = ctrl_q;
    if (expiry && !ctrl_q[1]) ctrl_d[0] = 1'b0;
    if (wr && idx == 3'd0 && wb.wb_sel_i[0]) ctrl_d = wb.wb_dat_i[2:0];
    exp_d    = expiry || (exp_q && !(wr && idx == 3'd1 && wb.wb_sel_i[0] && wb.wb_dat_i[0]));
    reload_d = (wr && idx == 3'd2) ? merge(reload_q, wb.wb_dat_i, wb.wb_sel_i) : reload_q;
    count_d  = (wr && idx == 3'd3) ? merge(count_q, wb.wb_dat_i, wb.wb_sel_i) :
               !tick ? count_q :
               count_q != 32'd0 ? count_q - 32'd1 :
               ctrl_q[1] ? reload_q : 32'd0;
  end
  always_ff @(posedge sys_clk or negedge sys_rst)
    if (!sys_rst) begin
      ctrl_q   <= '0;
      exp_q    <= 1'b0;
      reload_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      exp_q    <= exp_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      ack_q    <= acc;
      if (acc) dat_q <= rd;
    end
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq_o       = exp_q & ctrl_q[2];
endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: directed scenario bench for wb_timer, with or without WB_TIMER_PRESCALER_EN.
module tb_wb_timer;
`ifdef WB_TIMER_PRESCALER_EN
  localparam int p_eff = 2;
  localparam logic [31:0] presc_exp = 32'd7;
`else
  localparam int p_eff = 0;
  localparam logic [31:0] presc_exp = 32'd0;
`endif
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic irq_o;
  int   cmp = 0, bad = 0, cyc_cnt = 0;
  wb_timer_if wb();
  wb_timer #(.PRESC_W(16)) dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .wb(wb), .irq_o(irq_o));
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

  task automatic bus(input logic w, input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] q, output int e);
    @(negedge sys_clk);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = w; wb.wb_cti_i = 3'b111;
    wb.wb_adr_i = {27'h2A5A5A5, idx, 2'b00}; wb.wb_dat_i = d; wb.wb_sel_i = s;
    @(posedge sys_clk); #1;
    e = cyc_cnt; q = wb.wb_dat_o;
    cmp++; if (wb.wb_ack_o !== 1'b1) begin bad++; $display("FAIL ack_high idx%0d: got %b need 1", idx, wb.wb_ack_o); end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    @(posedge sys_clk); #1;
    cmp++; if (wb.wb_ack_o !== 1'b0) begin bad++; $display("FAIL ack_low idx%0d: got %b need 0", idx, wb.wb_ack_o); end
  endtask

  task automatic wait_edge(input int t);
    while (cyc_cnt < t) begin @(posedge sys_clk); #1; end
  endtask

  task automatic test_reset;
    logic [31:0] q;
    int e;
    #2 sys_rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    cmp++; if ({wb.wb_ack_o, wb.wb_dat_o, irq_o} !== 34'd0) begin bad++; $display("FAIL reset_outs: got %h need 0", {wb.wb_ack_o, wb.wb_dat_o, irq_o}); end
    @(negedge sys_clk) sys_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus(1'b0, 3'(i), 32'h0, 4'hF, q, e);
      cmp++; if (q !== 32'd0) begin bad++; $display("FAIL reset_read%0d: got %h need 0", i, q); end
    end
  endtask

  task automatic test_byte_enable;
    logic [31:0] q;
    int e;
    bus(1'b1, 3'd2, 32'h0, 4'hF, q, e);
    bus(1'b1, 3'd2, 32'hAABBCCDD, 4'b0101, q, e);
    bus(1'b0, 3'd2, 32'h0, 4'hF, q, e);
    cmp++; if (q !== 32'h00BB00DD) begin bad++; $display("FAIL sel_write: got %h need 00bb00dd", q); end
    bus(1'b1, 3'd2, 32'h11223344, 4'hF, q, e);
    cmp++; if (q !== 32'h00BB00DD) begin bad++; $display("FAIL prewrite_dat: got %h need 00bb00dd", q); end
    bus(1'b0, 3'd2, 32'h0, 4'hF, q, e);
    cmp++; if (q !== 32'h11223344) begin bad++; $display("FAIL full_write: got %h need 11223344", q); end
  endtask

  task automatic test_abort;
    logic [31:0] q;
    int e;
    @(negedge sys_clk);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b1;
    wb.wb_adr_i = 32'hC; wb.wb_dat_i = 32'h9; wb.wb_sel_i = 4'hF;
    @(posedge sys_clk); #1;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b1;
    @(posedge sys_clk); #1;
    cmp++; if (wb.wb_ack_o !== 1'b0) begin bad++; $display("FAIL abort_ack: got %b need 0", wb.wb_ack_o); end
    wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    bus(1'b0, 3'd3, 32'h0, 4'hF, q, e);
    cmp++; if (q !== 32'd0) begin bad++; $display("FAIL abort_count: got %h need 0", q); end
  endtask

  task automatic test_oneshot;
    logic [31:0] q;
    int n;
    bus(1'b1, 3'd3, 32'd3, 4'hF, q, n);
    bus(1'b1, 3'd4, 32'd0, 4'hF, q, n);
    bus(1'b1, 3'd0, 32'h5, 4'h1, q, n);
    wait_edge(n + 3);
    cmp++; if (irq_o !== 1'b0) begin bad++; $display("FAIL oneshot_irq_early: got %b need 0", irq_o); end
    wait_edge(n + 4);
    cmp++; if (irq_o !== 1'b1) begin bad++; $display("FAIL oneshot_irq: got %b need 1", irq_o); end
    bus(1'b0, 3'd0, 32'h0, 4'hF, q, n);
    cmp++; if (q !== 32'h4) begin bad++; $display("FAIL oneshot_ctrl: got %h need 4", q); end
    bus(1'b0, 3'd3, 32'h0, 4'hF, q, n);
    cmp++; if (q !== 32'd0) begin bad++; $display("FAIL oneshot_count: got %h need 0", q); end
    bus(1'b0, 3'd1, 32'h0, 4'hF, q, n);
    cmp++; if (q !== 32'd1) begin bad++; $display("FAIL oneshot_status: got %h need 1", q); end
  endtask

  task automatic test_autoreload_and_race;
    logic [31:0] q;
    int n, e, t;
    bus(1'b1, 3'd1, 32'h1, 4'h1, q, e);
    cmp++; if (irq_o !== 1'b0) begin bad++; $display("FAIL w1c_irq: got %b need 0", irq_o); end
    bus(1'b1, 3'd2, 32'd4, 4'hF, q, e);
    bus(1'b1, 3'd4, 32'd2, 4'hF, q, e);
    bus(1'b1, 3'd3, 32'd4, 4'hF, q, e);
    bus(1'b1, 3'd0, 32'h7, 4'hF, q, n);
    for (int k = 1; k <= 2; k++) begin
      t = n + 5 * k * (p_eff + 1);
      wait_edge(t - 1);
      cmp++; if (irq_o !== 1'b0) begin bad++; $display("FAIL period%0d_early: got %b need 0", k, irq_o); end
      wait_edge(t);
      cmp++; if (irq_o !== 1'b1) begin bad++; $display("FAIL period%0d_expiry: got %b need 1", k, irq_o); end
      bus(1'b1, 3'd1, 32'h1, 4'h1, q, e);
      cmp++; if (irq_o !== 1'b0) begin bad++; $display("FAIL period%0d_clear: got %b need 0", k, irq_o); end
    end
    t = n + 15 * (p_eff + 1);
    wait_edge(t - 1);
    bus(1'b1, 3'd1, 32'h1, 4'h1, q, e);
    cmp++; if (e !== t) begin bad++; $display("FAIL race_edge: got %0d need %0d", e, t); end
    bus(1'b0, 3'd1, 32'h0, 4'hF, q, e);
    cmp++; if (q !== 32'd1) begin bad++; $display("FAIL race_status: got %h need 1", q); end
    bus(1'b1, 3'd0, 32'h4, 4'h1, q, e);
    bus(1'b1, 3'd1, 32'h1, 4'h1, q, e);
    bus(1'b0, 3'd1, 32'h0, 4'hF, q, e);
    cmp++; if ({q, irq_o} !== 33'd0) begin bad++; $display("FAIL race_second_clear: got %h need 0", {q, irq_o}); end
  endtask

  task automatic test_midop_reset;
    logic [31:0] q;
    int n;
    bus(1'b1, 3'd3, 32'd0, 4'hF, q, n);
    bus(1'b1, 3'd0, 32'h7, 4'hF, q, n);
    wait_edge(n + p_eff + 2);
    cmp++; if (irq_o !== 1'b1) begin bad++; $display("FAIL midop_running_irq: got %b need 1", irq_o); end
    @(negedge sys_clk);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0; wb.wb_adr_i = 32'h0; wb.wb_sel_i = 4'hF;
    @(posedge sys_clk); #1;
    cmp++; if (wb.wb_ack_o !== 1'b1) begin bad++; $display("FAIL midop_ack: got %b need 1", wb.wb_ack_o); end
    #1 wb.wb_we_i = 1'b1; wb.wb_adr_i = 32'h8; wb.wb_dat_i = 32'h1234;
    #1 sys_rst = 1'b0;
    #1;
    cmp++; if ({wb.wb_ack_o, wb.wb_dat_o, irq_o} !== 34'd0) begin bad++; $display("FAIL midop_outs: got %h need 0", {wb.wb_ack_o, wb.wb_dat_o, irq_o}); end
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    sys_rst = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1;
    cmp++; if (irq_o !== 1'b0) begin bad++; $display("FAIL midop_idle_irq: got %b need 0", irq_o); end
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, 3'(i), 32'h0, 4'hF, q, n);
      cmp++; if (q !== 32'd0) begin bad++; $display("FAIL midop_read%0d: got %h need 0", i, q); end
    end
  endtask

  task automatic test_presc_reg;
    logic [31:0] q;
    int e;
    bus(1'b1, 3'd4, 32'd7, 4'hF, q, e);
    bus(1'b0, 3'd4, 32'h0, 4'hF, q, e);
    cmp++; if (q !== presc_exp) begin bad++; $display("FAIL presc_read: got %h need %h", q, presc_exp); end
  endtask

  initial begin
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0; wb.wb_cti_i = '0;
    test_reset;
    test_byte_enable;
    test_abort;
    test_oneshot;
    test_autoreload_and_race;
    test_midop_reset;
    test_presc_reg;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
